// File: rtl/digit_serial_alu.sv
// Digit-serial integer ALU: XLEN-bit operands processed DIGIT_W bits per cycle, LSB digit first.
// Optional shifts (SLL/SRL/SRA, one bit per cycle) are built when ALU_SHIFT_EN is defined.
module digit_serial_alu #(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_eq,
  output logic            out_lt,
  output logic            out_err
);

  localparam int NDIG  = XLEN / DIGIT_W;
  localparam int CNT_W = ($clog2(NDIG) > 5) ? $clog2(NDIG) : 5;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if ((XLEN % DIGIT_W) != 0) begin : g_bad_digit_w
    $error("digit_serial_alu: DIGIT_W must divide XLEN");
  end

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SEQ  = 4'd7;
`ifdef ALU_SHIFT_EN
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_SHIFT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
`endif

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // in_ready depends combinationally on out_ready in DONE so a new op can enter on the retire edge.
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              carry_q, carry_d;
  logic              eq_q, eq_d;
  logic              lt_q, lt_d;
  logic              err_q, err_d;

  logic [DIGIT_W-1:0]      a_dig, b_dig, b_add, op_dig;
  logic [DIGIT_W:0]        sum;
  logic [XLEN+DIGIT_W-1:0] res_cat;
  logic                    dig_eq, dig_lt;
  logic                    accept;

  assign in_ready   = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state_q == S_DONE);
  assign out_result = out_valid ? res_q : '0;
  assign out_eq     = out_valid & eq_q;
  assign out_lt     = out_valid & lt_q;
  assign out_err    = out_valid & err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    err_d   = err_q;

    a_dig  = a_q[DIGIT_W-1:0];
    b_dig  = b_q[DIGIT_W-1:0];
    b_add  = (op_q == OP_SUB) ? ~b_dig : b_dig;
    sum    = {1'b0, a_dig} + {1'b0, b_add} + {{DIGIT_W{1'b0}}, carry_q};
    dig_eq = (a_dig == b_dig);
    dig_lt = (a_dig < b_dig);

    case (op_q)
      OP_ADD, OP_SUB: op_dig = sum[DIGIT_W-1:0];
      OP_XOR:         op_dig = a_dig ^ b_dig;
      OP_OR:          op_dig = a_dig | b_dig;
      OP_AND:         op_dig = a_dig & b_dig;
      default:        op_dig = '0;
    endcase
    res_cat = {op_dig, res_q};

    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        if (err_q) begin
          res_d   = '0;
          state_d = S_DONE;
        end else begin
          carry_d = sum[DIGIT_W];
          eq_d    = eq_q & dig_eq;
          lt_d    = dig_lt | (dig_eq & lt_q);
          a_d     = a_q >> DIGIT_W;
          b_d     = b_q >> DIGIT_W;
          res_d   = res_cat[XLEN+DIGIT_W-1:DIGIT_W];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_DIG) begin
            // Signs differ on the top digit: the negative operand is the smaller one.
            if ((op_q == OP_SLT) && (a_dig[DIGIT_W-1] != b_dig[DIGIT_W-1]))
              lt_d = a_dig[DIGIT_W-1];
            if ((op_q == OP_SLT) || (op_q == OP_SLTU))
              res_d = {{(XLEN-1){1'b0}}, lt_d};
            else if (op_q == OP_SEQ)
              res_d = {{(XLEN-1){1'b0}}, eq_d};
            state_d = S_DONE;
          end
        end
      end
`ifdef ALU_SHIFT_EN
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          case (op_q)
            OP_SLL:  res_d = {res_q[XLEN-2:0], 1'b0};
            OP_SRL:  res_d = {1'b0, res_q[XLEN-1:1]};
            default: res_d = {res_q[XLEN-1], res_q[XLEN-1:1]};
          endcase
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Accept overrides the DONE->IDLE retire so back-to-back ops have no bubble.
    if (accept) begin
      op_d    = in_op;
      a_d     = in_a;
      b_d     = in_b;
      res_d   = '0;
      cnt_d   = '0;
      carry_d = (in_op == OP_SUB);
      eq_d    = 1'b1;
      lt_d    = 1'b0;
      err_d   = 1'b0;
      state_d = S_RUN;
      if (in_op > OP_SEQ) begin
        eq_d = 1'b0;
`ifdef ALU_SHIFT_EN
        if (in_op <= OP_SRA) begin
          state_d = S_SHIFT;
          cnt_d   = CNT_W'(in_b[4:0]);
          res_d   = in_a;
        end else begin
          err_d = 1'b1;
        end
`else
        err_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_digit_serial_alu.sv
// Bench for digit_serial_alu (XLEN=32, DIGIT_W=4): vector table plus handshake/reset sequences.
`timescale 1ns/1ps
module tb_digit_serial_alu;

  localparam int XLEN    = 32;
  localparam int DIGIT_W = 4;
  localparam int NV      = 18;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SEQ  = 4'd7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_op = '0;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_result;
  logic            out_eq;
  logic            out_lt;
  logic            out_err;

  digit_serial_alu #(.XLEN(XLEN), .DIGIT_W(DIGIT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_eq     (out_eq),
    .out_lt     (out_lt),
    .out_err    (out_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 ns, required to finish earlier");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic            eq;
    logic            lt;
    logic            err;
    int              lat;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: waited %0d cycles, required in_ready within 200", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Returns the number of rising edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: out_valid=0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic collect(input string tag, input logic eq, input logic lt, input logic err,
                         input int lat_exp);
    int lat;
    logic [XLEN-1:0] e;
    wait_valid(lat);
    e = exp_q.pop_front();
    check({tag, "_result"}, out_result, e);
    check({tag, "_eq"}, out_eq, eq);
    check({tag, "_lt"}, out_lt, lt);
    check({tag, "_err"}, out_err, err);
    check({tag, "_latency"}, lat, lat_exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic stale;

    vecs[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 8};
    vecs[1]  = '{OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 8};
    vecs[2]  = '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0, 8};
    vecs[3]  = '{OP_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 8};
    vecs[4]  = '{OP_SEQ,  32'h1234ABCD, 32'h1234ABCD, 32'h00000001, 1'b1, 1'b0, 1'b0, 8};
    vecs[5]  = '{OP_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1'b0, 8};
    vecs[6]  = '{OP_OR,   32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0, 8};
    vecs[7]  = '{OP_AND,  32'hDEADBEEF, 32'h0000FFFF, 32'h0000BEEF, 1'b0, 1'b0, 1'b0, 8};
    vecs[8]  = '{OP_ADD,  32'h12345678, 32'h87654321, 32'h99999999, 1'b0, 1'b1, 1'b0, 8};
    vecs[9]  = '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 8};
    vecs[10] = '{OP_SLT,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 8};
    vecs[11] = '{OP_SLT,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 8};
    vecs[12] = '{OP_SLTU, 32'h00000003, 32'h00000010, 32'h00000001, 1'b0, 1'b1, 1'b0, 8};
    vecs[13] = '{4'd12,   32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
    vecs[14] = '{4'd15,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
`ifdef ALU_SHIFT_EN
    vecs[15] = '{4'd10,   32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b0, 5};
    vecs[16] = '{4'd8,    32'h13579BDF, 32'h00000020, 32'h13579BDF, 1'b0, 1'b0, 1'b0, 1};
    vecs[17] = '{4'd9,    32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0, 32};
`else
    vecs[15] = '{4'd8,    32'h00000001, 32'h00000004, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
    vecs[16] = '{4'd9,    32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
    vecs[17] = '{4'd10,   32'h80000000, 32'h00000004, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
`endif

    // reset state
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, '0);
    check("rst_out_err", out_err, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);

    // vector table
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(vecs[i].res);
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      collect($sformatf("vec%0d", i), vecs[i].eq, vecs[i].lt, vecs[i].err, vecs[i].lat);
    end

    // back-to-back: second op accepted on the edge the first retires
    out_ready = 1'b1;
    exp_q.push_back(32'hA5A55A5A);
    exp_q.push_back(32'h0A0A0505);
    send(OP_XOR, 32'hAAAA5555, 32'h0F0F0F0F);
    wait_valid(lat);
    check("b2b_first_result", out_result, exp_q.pop_front());
    in_valid = 1'b1;
    in_op    = OP_AND;
    in_a     = 32'hAAAA5555;
    in_b     = 32'h0F0F0F0F;
    #1;
    check("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    collect("b2b_second", 1'b0, 1'b0, 1'b0, 8);

    // backpressure: result held for 5 cycles, a waiting op is not taken
    out_ready = 1'b0;
    exp_q.push_back(32'h33333333);
    exp_q.push_back(32'h00000007);
    send(OP_ADD, 32'h11111111, 32'h22222222);
    wait_valid(lat);
    in_valid = 1'b1;
    in_op    = OP_SUB;
    in_a     = 32'd10;
    in_b     = 32'd3;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid_%0d", k), out_valid, 1'b1);
      check($sformatf("bp_result_%0d", k), out_result, exp_q[0]);
      check($sformatf("bp_lt_%0d", k), out_lt, 1'b1);
      check($sformatf("bp_in_ready_%0d", k), in_ready, 1'b0);
      @(negedge clk);
    end
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    collect("bp_next", 1'b0, 1'b0, 1'b0, 8);

    // reset during digit 3 of an ADD
    send(OP_ADD, 32'h00000001, 32'h00000002);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", out_valid, 1'b0);
    check("midrun_rst_in_ready", in_ready, 1'b0);
    check("midrun_rst_result", out_result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("midrun_no_stale_valid", stale, 1'b0);
    check("midrun_in_ready", in_ready, 1'b1);

    // reset while a result is held in DONE
    out_ready = 1'b0;
    send(OP_OR, 32'hFFFF0000, 32'h0000FFFF);
    wait_valid(lat);
    check("done_hold_result", out_result, 32'hFFFFFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("done_rst_out_valid", out_valid, 1'b0);
    check("done_rst_result", out_result, '0);
    check("done_rst_lt", out_lt, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("done_rst_idle_valid", out_valid, 1'b0);
    check("done_rst_idle_ready", in_ready, 1'b1);

    // recovery after reset
    exp_q.push_back(32'h00000005);
    send(OP_ADD, 32'h00000002, 32'h00000003);
    collect("recover", 1'b0, 1'b1, 1'b0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
